// File: rtl/pipe_reg_de.sv
// pipe_reg_de: decode-to-execute (ID/EX) pipeline register.
// Captures decoded control, operands, immediate, PC and register addresses
// from decode and presents them to execute one cycle later. Supports stall
// (hold), flush (bubble insertion) and a valid bit that masks control.
// Optional feature macro: PIPE_REG_DE_PERF_EN adds saturating bubble/stall
// counters (bubble_cnt, stall_cnt). Undefined by default.
module pipe_reg_de #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_E,
    input  logic                  flush_E,
    input  logic                  valid_D,
    input  logic                  RegWrite_D,
    input  logic                  MemWrite_D,
    input  logic                  jump_D,
    input  logic                  ALUsrc_D,
    input  logic [1:0]            ResultSrc_D,
    input  logic [2:0]            branch_D,
    input  logic [3:0]            ALUctrl_D,
    input  logic [DATA_WIDTH-1:0] RD1_D,
    input  logic [DATA_WIDTH-1:0] RD2_D,
    input  logic [DATA_WIDTH-1:0] ImmOp_D,
    input  logic [DATA_WIDTH-1:0] PC_D,
    input  logic [DATA_WIDTH-1:0] PCplus4_D,
    input  logic [ADDR_WIDTH-1:0] Rs1_D,
    input  logic [ADDR_WIDTH-1:0] Rs2_D,
    input  logic [ADDR_WIDTH-1:0] Rd_D,
    output logic                  valid_E,
    output logic                  RegWrite_E,
    output logic                  MemWrite_E,
    output logic                  jump_E,
    output logic                  ALUsrc_E,
    output logic [1:0]            ResultSrc_E,
    output logic [2:0]            branch_E,
    output logic [3:0]            ALUctrl_E,
    output logic [DATA_WIDTH-1:0] RD1_E,
    output logic [DATA_WIDTH-1:0] RD2_E,
    output logic [DATA_WIDTH-1:0] ImmOp_E,
    output logic [DATA_WIDTH-1:0] PC_E,
    output logic [DATA_WIDTH-1:0] PCplus4_E,
    output logic [ADDR_WIDTH-1:0] Rs1_E,
    output logic [ADDR_WIDTH-1:0] Rs2_E,
    output logic [ADDR_WIDTH-1:0] Rd_E
`ifdef PIPE_REG_DE_PERF_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    // ID/EX register: reset and flush load a bubble, stall holds, else load.
    // Control bits that cause side effects are masked when decode is invalid;
    // register addresses are cleared on a bubble so x0 is never forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_E     <= 1'b0;
            RegWrite_E  <= 1'b0;
            MemWrite_E  <= 1'b0;
            jump_E      <= 1'b0;
            ALUsrc_E    <= 1'b0;
            ResultSrc_E <= 2'b00;
            branch_E    <= 3'b000;
            ALUctrl_E   <= 4'h0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            ImmOp_E     <= '0;
            PC_E        <= '0;
            PCplus4_E   <= '0;
            Rs1_E       <= '0;
            Rs2_E       <= '0;
            Rd_E        <= '0;
        end else if (flush_E) begin
            valid_E     <= 1'b0;
            RegWrite_E  <= 1'b0;
            MemWrite_E  <= 1'b0;
            jump_E      <= 1'b0;
            ALUsrc_E    <= 1'b0;
            ResultSrc_E <= 2'b00;
            branch_E    <= 3'b000;
            ALUctrl_E   <= 4'h0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            ImmOp_E     <= '0;
            PC_E        <= '0;
            PCplus4_E   <= '0;
            Rs1_E       <= '0;
            Rs2_E       <= '0;
            Rd_E        <= '0;
        end else if (stall_E) begin
            // Hold: every E-side flop keeps its value, including valid_E.
            valid_E     <= valid_E;
        end else begin
            valid_E     <= valid_D;
            RegWrite_E  <= RegWrite_D & valid_D;
            MemWrite_E  <= MemWrite_D & valid_D;
            jump_E      <= jump_D & valid_D;
            branch_E    <= valid_D ? branch_D : 3'b000;
            ALUsrc_E    <= ALUsrc_D;
            ResultSrc_E <= ResultSrc_D;
            ALUctrl_E   <= ALUctrl_D;
            RD1_E       <= RD1_D;
            RD2_E       <= RD2_D;
            ImmOp_E     <= ImmOp_D;
            PC_E        <= PC_D;
            PCplus4_E   <= PCplus4_D;
            Rs1_E       <= Rs1_D;
            Rs2_E       <= Rs2_D;
            Rd_E        <= Rd_D;
        end
    end

`ifdef PIPE_REG_DE_PERF_EN
    // Saturating counters of inserted bubbles and stall-only cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= 32'h0000_0000;
            stall_cnt  <= 32'h0000_0000;
        end else if (flush_E) begin
            if (bubble_cnt != 32'hFFFF_FFFF) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end else begin
                bubble_cnt <= bubble_cnt;
            end
        end else if (stall_E) begin
            if (stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
        end else begin
            bubble_cnt <= bubble_cnt;
            stall_cnt  <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_de.sv
// Self-checking bench for pipe_reg_de: directed steps with a scoreboard
// queue of expected E-side bundles. With PIPE_REG_DE_PERF_EN defined it
// also checks the bubble/stall counters.
module tb_pipe_reg_de;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        jump;
        logic        alusrc;
        logic [1:0]  resultsrc;
        logic [2:0]  branch;
        logic [3:0]  aluctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    logic    clk;
    logic    rst;
    logic    stall;
    logic    flush;
    bundle_t din;
    bundle_t obs;
    bundle_t mdl;
    bundle_t sb[$];
    int      compared;
    int      mismatched;

    logic        valid_E, RegWrite_E, MemWrite_E, jump_E, ALUsrc_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  branch_E;
    logic [3:0]  ALUctrl_E;
    logic [31:0] RD1_E, RD2_E, ImmOp_E, PC_E, PCplus4_E;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;
`ifdef PIPE_REG_DE_PERF_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    pipe_reg_de #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .stall_E(stall), .flush_E(flush),
        .valid_D(din.valid), .RegWrite_D(din.regwrite), .MemWrite_D(din.memwrite),
        .jump_D(din.jump), .ALUsrc_D(din.alusrc), .ResultSrc_D(din.resultsrc),
        .branch_D(din.branch), .ALUctrl_D(din.aluctrl),
        .RD1_D(din.rd1), .RD2_D(din.rd2), .ImmOp_D(din.imm), .PC_D(din.pc),
        .PCplus4_D(din.pcp4), .Rs1_D(din.rs1), .Rs2_D(din.rs2), .Rd_D(din.rd),
        .valid_E(valid_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
        .jump_E(jump_E), .ALUsrc_E(ALUsrc_E), .ResultSrc_E(ResultSrc_E),
        .branch_E(branch_E), .ALUctrl_E(ALUctrl_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmOp_E(ImmOp_E), .PC_E(PC_E),
        .PCplus4_E(PCplus4_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E)
`ifdef PIPE_REG_DE_PERF_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    assign obs = '{valid_E, RegWrite_E, MemWrite_E, jump_E, ALUsrc_E, ResultSrc_E,
                   branch_E, ALUctrl_E, RD1_E, RD2_E, ImmOp_E, PC_E, PCplus4_E,
                   Rs1_E, Rs2_E, Rd_E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] o, input logic [BW-1:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Push the expected bundle for the current inputs, clock once, then pop and compare.
    task automatic step(input string tag);
        bundle_t e;
        if (flush) begin
            e = '0;
        end else if (stall) begin
            e = mdl;
        end else begin
            e = din;
            if (!din.valid) begin
                e.regwrite = 1'b0;
                e.memwrite = 1'b0;
                e.jump     = 1'b0;
                e.branch   = 3'b000;
            end
        end
        mdl = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(tag, obs, sb.pop_front());
    endtask

    task automatic set_nonzero();
        din = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 3'b101, 4'hA,
                32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_1000,
                32'h0000_1004, 5'd1, 5'd2, 5'd3};
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        mdl        = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        set_nonzero();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, '0);
        @(negedge clk);
        rst = 1'b0;

        // Load nonzero, then assert reset mid-cycle: outputs clear before next edge.
        step("load_nonzero");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_bundle", obs, '0);
        check("async_reset_valid", {{(BW-1){1'b0}}, valid_E}, {BW{1'b0}});
        mdl = '0;
        @(negedge clk);
        rst = 1'b0;

        // Plain load.
        din = '0;
        din.valid = 1'b1; din.rd1 = 32'h0000_0005; din.imm = 32'hFFFF_FFFC;
        din.rd = 5'd7; din.regwrite = 1'b1; din.aluctrl = 4'h0;
        step("plain_load");
        check("plain_load_rd1", {{(BW-32){1'b0}}, RD1_E}, {{(BW-32){1'b0}}, 32'h0000_0005});
        check("plain_load_imm", {{(BW-32){1'b0}}, ImmOp_E}, {{(BW-32){1'b0}}, 32'hFFFF_FFFC});

        // Stall for 3 cycles while decode changes.
        stall = 1'b1;
        din.rd1 = 32'h0000_00AA;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall_rd1", {{(BW-32){1'b0}}, RD1_E}, {{(BW-32){1'b0}}, 32'h0000_0005});
            check("stall_rd", {{(BW-5){1'b0}}, Rd_E}, {{(BW-5){1'b0}}, 5'd7});
        end
        stall = 1'b0;
        step("stall_release");
        check("release_rd1", {{(BW-32){1'b0}}, RD1_E}, {{(BW-32){1'b0}}, 32'h0000_00AA});

        // Flush beats stall.
        stall = 1'b1; flush = 1'b1;
        din.jump = 1'b1; din.branch = 3'b001; din.rd = 5'd3;
        step("flush_beats_stall");
        stall = 1'b0; flush = 1'b0;

        // Invalid decode masks control but data still loads.
        din.valid = 1'b0; din.regwrite = 1'b1; din.memwrite = 1'b1;
        din.branch = 3'b010; din.jump = 1'b1; din.rd2 = 32'h1234_5678;
        step("invalid_decode");
        check("invalid_rd2", {{(BW-32){1'b0}}, RD2_E}, {{(BW-32){1'b0}}, 32'h1234_5678});

        // Mixed random traffic against the model.
        for (int i = 0; i < 24; i++) begin
            din   = bundle_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            step("random_mix");
        end
        stall = 1'b0; flush = 1'b0;

`ifdef PIPE_REG_DE_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        mdl = '0;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b1;
        repeat (4) step("perf_flush");
        flush = 1'b0; stall = 1'b1;
        repeat (2) step("perf_stall");
        flush = 1'b1;
        step("perf_both");
        check("bubble_cnt", {{(BW-32){1'b0}}, bubble_cnt}, {{(BW-32){1'b0}}, 32'd5});
        check("stall_cnt", {{(BW-32){1'b0}}, stall_cnt}, {{(BW-32){1'b0}}, 32'd2});
        @(negedge clk);
        force dut.bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt;
        stall = 1'b0;
        step("perf_sat_flush");
        check("bubble_sat", {{(BW-32){1'b0}}, bubble_cnt}, {{(BW-32){1'b0}}, 32'hFFFF_FFFF});
        flush = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_reg_de.md
Name: pipe_reg_de

Overview:
- Decode-to-execute (ID/EX) pipeline register.
- Sits directly upstream of the execute stage. Captures decoded control, register operands, immediate, PC and destination register from decode each cycle.
- Presents them to execute for the following cycle.
- Supports hold (stall), bubble insertion (flush) and a valid bit, so hazard logic and taken branches/jumps can cancel instructions cleanly.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC datapaths
- ADDR_WIDTH, 5, register-file address width for rs1/rs2/rd

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- stall_E  input  1  hold all E-side outputs at current value
- flush_E  input  1  load a bubble (NOP) into the E-side register
- valid_D  input  1  decode holds a real instruction
- RegWrite_D, MemWrite_D, jump_D, ALUsrc_D  input  1 each  decoded control bits
- ResultSrc_D  input  2  writeback result select
- branch_D  input  3  branch type (0 = not a branch)
- ALUctrl_D  input  4  ALU operation
- RD1_D, RD2_D, ImmOp_D, PC_D, PCplus4_D  input  DATA_WIDTH each  decode data
- Rs1_D, Rs2_D, Rd_D  input  ADDR_WIDTH each  register addresses
- valid_E, RegWrite_E, MemWrite_E, jump_E, ALUsrc_E  output  1 each  registered copies
- ResultSrc_E  output  2  registered copy
- branch_E  output  3  registered copy
- ALUctrl_E  output  4  registered copy
- RD1_E, RD2_E, ImmOp_E, PC_E, PCplus4_E  output  DATA_WIDTH each  registered copies
- Rs1_E, Rs2_E, Rd_E  output  ADDR_WIDTH each  registered copies

Behaviour:
- All outputs driven directly from flops; no combinational input-to-output path. Latency is 1 cycle.
- Reset: asynchronous assert, synchronous-release safe. All outputs go to 0, i.e. a bubble: valid_E=0, RegWrite_E=0, MemWrite_E=0, jump_E=0, branch_E=0, all data 0.
- Priority at each rising edge: rst > flush_E > stall_E > load.
- Load (no flush, no stall): every E output takes its _D input.
  - valid_E = valid_D.
  - If valid_D=0, the control bits RegWrite_E, MemWrite_E, jump_E and branch_E are forced to 0 regardless of their _D values. Data fields still load.
- Stall (stall_E=1, flush_E=0): all E outputs hold their previous values, including valid_E.
- Flush (flush_E=1): valid_E, RegWrite_E, MemWrite_E, jump_E and branch_E are cleared.
  - Rd_E, Rs1_E and Rs2_E are cleared to 0, so x0 is never forwarded.
  - Data fields (RD1/RD2/ImmOp/PC/PCplus4) and ALUctrl_E/ALUsrc_E/ResultSrc_E are also cleared to 0.
- flush_E and stall_E both asserted: flush wins and the bubble is inserted.
- Flush is driven by the hazard unit on a taken branch/jump (execute's PCsrc) or on a load-use bubble. The block does not compute it.
- Reset asserted mid-stall or mid-flush: outputs go to 0 immediately, asynchronously. The first edge after release performs a normal load, or a stall/flush per its inputs.

Optional Feature:
- Macro: PIPE_REG_DE_PERF_EN.
- Defined: adds outputs bubble_cnt [31:0] and stall_cnt [31:0], both reset to 0.
  - bubble_cnt increments on each edge where flush_E=1.
  - stall_cnt increments on each edge where stall_E=1 and flush_E=0.
  - Both saturate at 32'hFFFF_FFFF with no wrap.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Reset: drive all _D inputs to nonzero and pulse rst mid-cycle. All outputs go to 0 before the next clk edge; valid_E=0.
- Plain load: valid_D=1, RD1_D=32'h0000_0005, ImmOp_D=32'hFFFF_FFFC, Rd_D=5'd7, RegWrite_D=1, ALUctrl_D=4'h0. The next edge shows the same values on the E side with valid_E=1.
- Stall: after the load above, set stall_E=1 for 3 cycles while changing RD1_D to 32'h0000_00AA. RD1_E stays 32'h0000_0005 and Rd_E stays 7 for all 3 cycles. On the edge after stall_E drops, RD1_E becomes 32'h0000_00AA.
- Flush beats stall: stall_E=1 and flush_E=1 with jump_D=1, branch_D=3'b001, Rd_D=5'd3. The next edge gives valid_E=0, jump_E=0, branch_E=0, RegWrite_E=0, Rd_E=0.
- Invalid decode: valid_D=0 with RegWrite_D=1, MemWrite_D=1 and branch_D=3'b010. The next edge gives valid_E=0 and all four control bits 0. RD2_D propagates to RD2_E.
- Perf (macro defined): 4 flush cycles, then 2 stall-only cycles, then 1 cycle with both asserted. Expect bubble_cnt=5 and stall_cnt=2. Forcing bubble_cnt to 32'hFFFF_FFFF and then flushing keeps it at 32'hFFFF_FFFF.
